// File: rtl/typ_out_pkg.sv
`default_nettype none
// typ_out_pkg: character codes, state/kind encodings and word-length default for the line-19 typewriter sequencer.
// Rev 1.0 -- initial release.
package typ_out_pkg;

  localparam int WORD_BITS_DFLT = 29;

  localparam logic [4:0] CH_SPACE = 5'h10;
  localparam logic [4:0] CH_MINUS = 5'h11;
  localparam logic [4:0] CH_CR    = 5'h12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_SEND  = 3'd2,
    ST_CAPD  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_CLR   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    K_SIGN  = 2'd0,
    K_DIGIT = 2'd1,
    K_CR    = 2'd2
  } kind_t;

  function automatic logic [4:0] digit_code(input logic [3:0] nib);
    return {1'b0, nib};
  endfunction

endpackage
`default_nettype wire

// File: rtl/typ_out_seq_bit_timer.sv
`default_nettype none
// typ_bit_timer: drum bit counter; reports the index of the bit being strobed and a word-start strobe.
// Rev 1.0 -- initial release.
module typ_bit_timer
  import typ_out_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DFLT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         bit_en_i,
  input  logic                         t0_i,
  output logic                         word_start_o,
  output logic [$clog2(WORD_BITS)-1:0] bit_cnt_o
);

  localparam int BW = $clog2(WORD_BITS);
  localparam logic [BW-1:0] c_last = BW'(WORD_BITS - 1);

  logic [BW-1:0] cnt_q;
  logic [BW-1:0] cnt_d;

  // cnt_q holds the index of the last strobed bit, so cnt_d is the index of the current one
  always_comb begin
    if (t0_i)                 cnt_d = '0;
    else if (cnt_q == c_last) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         cnt_q <= '0;
    else if (bit_en_i) cnt_q <= cnt_d;
  end

  assign word_start_o = bit_en_i & t0_i;
  assign bit_cnt_o    = cnt_d;

endmodule
`default_nettype wire

// File: rtl/typ_out_seq.sv
`default_nettype none
// typ_out_seq: types each line-19 word as sign, hex digits and CR, driving TYPE1/2/3/READY toward mem_top.
// Rev 1.0 -- initial release. Option: TYP_ZERO_SUPPRESS_EN (leading-zero digits typed as SPACE).
module typ_out_seq
  import typ_out_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DFLT,
  parameter int DIGITS    = 7
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       BIT_EN,
  input  logic       T0,
  input  logic       M19,
  input  logic       OUT_GO,
  input  logic       CHAR_ACK,
  output logic [4:0] CHAR_CODE,
  output logic       CHAR_VALID,
  output logic       TYPE1,
  output logic       TYPE2,
  output logic       TYPE3,
  output logic       READY
);

  localparam int BW = $clog2(WORD_BITS);
  localparam logic [BW-1:0] c_nib_lsb = BW'(WORD_BITS - 4);
  localparam logic [BW-1:0] c_last    = BW'(WORD_BITS - 1);
  localparam logic [2:0]    c_digits  = 3'(DIGITS);

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [4:0]    code_q, code_d;
  logic [3:0]    nib_q, nib_d;
  logic [2:0]    dcnt_q, dcnt_d;
  logic          arm_q, arm_d;
  logic          win_q, win_d;
  logic          w_ws;
  logic [BW-1:0] w_bit;
  logic          w_cap;
  logic          w_cap_last;
  logic [3:0]    w_nib;
  logic [4:0]    w_dcode;

  typ_bit_timer #(.WORD_BITS(WORD_BITS)) u_bit_timer (
    .clk_i        (CLOCK),
    .rst_i        (rst),
    .bit_en_i     (BIT_EN),
    .t0_i         (T0),
    .word_start_o (w_ws),
    .bit_cnt_o    (w_bit)
  );

  // arm_q marks that a word start has been seen in CAPD, so only a whole word is captured
  assign w_cap      = (state_q == ST_CAPD) && arm_q && BIT_EN && (w_bit >= c_nib_lsb);
  assign w_cap_last = w_cap && (w_bit == c_last);
  assign w_nib      = {M19, nib_q[3:1]};

`ifdef TYP_ZERO_SUPPRESS_EN
  logic nz_q, nz_d;

  always_comb begin
    nz_d = nz_q;
    if (state_q == ST_IDLE)                   nz_d = 1'b0;
    else if (w_cap_last && (w_nib != 4'd0))   nz_d = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (rst) nz_q <= 1'b0;
    else     nz_q <= nz_d;
  end

  assign w_dcode = ((w_nib == 4'd0) && !nz_q && ((dcnt_q + 3'd1) != c_digits)) ? CH_SPACE
                                                                                : digit_code(w_nib);
`else
  assign w_dcode = digit_code(w_nib);
`endif

  always_ff @(posedge CLOCK) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (OUT_GO) state_d = ST_SYNC;
      ST_SYNC:  if (w_ws) state_d = ST_SEND;
      ST_SEND: begin
        if (CHAR_ACK) begin
          case (kind_q)
            K_SIGN:  state_d = ST_CAPD;
            K_DIGIT: state_d = (dcnt_q < c_digits) ? ST_SHIFT : ST_SEND;
            default: state_d = ST_CLR;
          endcase
        end
      end
      ST_CAPD:  if (w_cap_last) state_d = ST_SEND;
      ST_SHIFT: if (w_ws && win_q) state_d = ST_CAPD;
      ST_CLR:   if (w_ws && win_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    CHAR_VALID = (state_q == ST_SEND);
    TYPE1      = (state_q != ST_IDLE);
    TYPE2      = (state_q == ST_SHIFT) && win_q;
    TYPE3      = (state_q == ST_CLR) && win_q;
    READY      = (state_q == ST_IDLE);
  end

  assign CHAR_CODE = code_q;

  always_comb begin
    kind_d = kind_q;
    code_d = code_q;
    nib_d  = nib_q;
    dcnt_d = dcnt_q;
    arm_d  = arm_q;
    win_d  = win_q;
    case (state_q)
      ST_IDLE: begin
        dcnt_d = '0;
        win_d  = 1'b0;
      end
      ST_SYNC: begin
        if (w_ws) begin
          code_d = M19 ? CH_MINUS : CH_SPACE;
          kind_d = K_SIGN;
        end
      end
      ST_SEND: begin
        if (CHAR_ACK) begin
          arm_d = 1'b0;
          if ((kind_q == K_DIGIT) && (dcnt_q >= c_digits)) begin
            code_d = CH_CR;
            kind_d = K_CR;
          end
        end
      end
      ST_CAPD: begin
        if (w_ws)  arm_d = 1'b1;
        if (w_cap) nib_d = w_nib;
        if (w_cap_last) begin
          code_d = w_dcode;
          dcnt_d = dcnt_q + 3'd1;
          kind_d = K_DIGIT;
        end
      end
      // The window opens on one word start and closes on the next; the closing T0 also arms capture
      ST_SHIFT: begin
        if (w_ws) begin
          win_d = !win_q;
          if (win_q) arm_d = 1'b1;
        end
      end
      ST_CLR: begin
        if (w_ws) begin
          win_d = !win_q;
          if (win_q) dcnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      kind_q <= K_SIGN;
      code_q <= '0;
      nib_q  <= '0;
      dcnt_q <= '0;
      arm_q  <= 1'b0;
      win_q  <= 1'b0;
    end else begin
      kind_q <= kind_d;
      code_q <= code_d;
      nib_q  <= nib_d;
      dcnt_q <= dcnt_d;
      arm_q  <= arm_d;
      win_q  <= win_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_typ_out_seq.sv
`default_nettype none
// tb_typ_out_seq: directed bench for typ_out_seq with a 29-bit line-19 drum model (TYPE2 shifts, TYPE3 clears).
// Rev 1.0 -- initial release.
module tb_typ_out_seq;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b1;
  logic       BIT_EN, T0, M19;
  logic       go7 = 1'b0, go1 = 1'b0;
  logic       CHAR_ACK = 1'b1;
  logic [4:0] code7, code1;
  logic       valid7, t1_7, t2_7, t3_7, rdy7;
  logic       valid1, t1_1, t2_1, t3_1, rdy1;

  int n_checks = 0;
  int n_errors = 0;

  // drum model state, written only by the drum process
  logic [28:0] line19 = '0;
  int          t2_win[$];
  int          t3_win[$];
  int          both_hi = 0;
  // requests from the main process
  logic [28:0] ld_val = '0;
  int          ld_req = 0;
  int          inj_req = 0;
  // accepted characters, written only by the monitor
  logic [4:0]  q7[$];
  logic [4:0]  q1[$];
  // base indices, written only by the main process
  int          b7, b1, bt2, bt3;

  typ_out_seq #(.WORD_BITS(29), .DIGITS(7)) u_dut7 (
    .CLOCK(CLOCK), .rst(rst), .BIT_EN(BIT_EN), .T0(T0), .M19(M19), .OUT_GO(go7),
    .CHAR_ACK(CHAR_ACK), .CHAR_CODE(code7), .CHAR_VALID(valid7), .TYPE1(t1_7),
    .TYPE2(t2_7), .TYPE3(t3_7), .READY(rdy7)
  );

  typ_out_seq #(.WORD_BITS(29), .DIGITS(1)) u_dut1 (
    .CLOCK(CLOCK), .rst(rst), .BIT_EN(BIT_EN), .T0(T0), .M19(M19), .OUT_GO(go1),
    .CHAR_ACK(CHAR_ACK), .CHAR_CODE(code1), .CHAR_VALID(valid1), .TYPE1(t1_1),
    .TYPE2(t2_1), .TYPE3(t3_1), .READY(rdy1)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_codes(input string name, input logic [4:0] got[$], input logic [4:0] exp[$]);
    check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_char%0d", name, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(exp[i]));
    end
  endtask

  // Drum: one bit every two clocks, T0 on bit 0; window effects applied at the following word start
  initial begin : drum
    int b, t2c, t3c, ld_seen, inj_seen;
    b = 0; t2c = 0; t3c = 0; ld_seen = 0; inj_seen = 0;
    BIT_EN = 1'b0; T0 = 1'b0; M19 = 1'b0;
    forever begin
      @(posedge CLOCK); #1;
      if (ld_req != ld_seen) begin ld_seen = ld_req; line19 = ld_val; end
      if ((inj_req != inj_seen) && (b == 10)) begin inj_seen = inj_req; b = 0; end
      if (b == 0) begin
        if (t2c > 0) begin t2_win.push_back(t2c); line19 = line19 << 4; end
        if (t3c > 0) begin t3_win.push_back(t3c); line19 = '0; end
        t2c = 0; t3c = 0;
      end
      BIT_EN = 1'b1; T0 = (b == 0); M19 = line19[b];
      @(posedge CLOCK); #1;
      BIT_EN = 1'b0; T0 = 1'b0;
      if (t2_7 | t2_1) t2c++;
      if (t3_7 | t3_1) t3c++;
      if ((t2_7 | t2_1) & (t3_7 | t3_1)) both_hi++;
      b = (b == 28) ? 0 : b + 1;
    end
  end

  always @(negedge CLOCK) begin
    if (!rst && CHAR_ACK) begin
      if (valid7) q7.push_back(code7);
      if (valid1) q1.push_back(code1);
    end
  end

  task automatic start7(input logic load, input logic [28:0] w);
    if (load) begin ld_val = w; ld_req++; end
    @(posedge CLOCK); #1;
    b7 = q7.size(); bt2 = t2_win.size(); bt3 = t3_win.size();
    go7 = 1'b1;
    @(posedge CLOCK); #1;
    go7 = 1'b0;
  endtask

  task automatic wait_done7(output logic done);
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge CLOCK);
      if ((q7.size() - b7 >= 9) && rdy7) done = 1'b1;
    end
  endtask

  initial begin : main
    logic       done, seen;
    logic [4:0] e[$];
    logic [4:0] code0;
    int         bad;

    repeat (4) @(posedge CLOCK);
    #1 rst = 1'b0;
    @(negedge CLOCK);
    check("rst_code", 32'(code7), 32'h0);
    check("rst_valid", 32'(valid7), 32'h0);
    check("rst_type1", 32'(t1_7), 32'h0);
    check("rst_type2", 32'(t2_7), 32'h0);
    check("rst_type3", 32'(t3_7), 32'h0);
    check("rst_ready", 32'(rdy7), 32'h1);

    // Basic word, ack held high
    start7(1'b1, {28'h0012345, 1'b1});
    @(negedge CLOCK);
    check("busy_type1", 32'(t1_7), 32'h1);
    check("busy_ready", 32'(rdy7), 32'h0);
    wait_done7(done);
    check("basic_done", 32'(done), 32'h1);
`ifdef TYP_ZERO_SUPPRESS_EN
    e = '{5'h11, 5'h10, 5'h10, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h12};
`else
    e = '{5'h11, 5'h00, 5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h12};
`endif
    check_codes("basic", q7[b7:$], e);
    check("basic_t2_windows", 32'(t2_win.size() - bt2), 32'd6);
    bad = 0;
    for (int i = bt2; i < t2_win.size(); i++) if (t2_win[i] != 29) bad++;
    check("basic_t2_len", 32'(bad), 32'd0);
    check("basic_t3_windows", 32'(t3_win.size() - bt3), 32'd1);
    check("basic_t3_len", (t3_win.size() > bt3) ? 32'(t3_win[bt3]) : 32'd0, 32'd29);
    check("basic_ready", 32'(rdy7), 32'h1);

    // All-zero word
    start7(1'b1, 29'h0);
    wait_done7(done);
    check("zero_done", 32'(done), 32'h1);
`ifdef TYP_ZERO_SUPPRESS_EN
    e = '{5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00, 5'h12};
`else
    e = '{5'h10, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h12};
`endif
    check_codes("zero", q7[b7:$], e);

    // Handshake stall on the sign character
    CHAR_ACK = 1'b0;
    start7(1'b1, {28'h89ABCDE, 1'b1});
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge CLOCK);
      if (valid7) done = 1'b1;
    end
    check("stall_valid_seen", 32'(done), 32'h1);
    code0 = code7;
    bad = 0; seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK);
      if ((code7 !== code0) || !valid7) bad++;
      if (t2_7) seen = 1'b1;
    end
    check("stall_code", 32'(code0), 32'h11);
    check("stall_stable", 32'(bad), 32'd0);
    check("stall_no_type2", 32'(seen), 32'h0);
    @(posedge CLOCK); #1 CHAR_ACK = 1'b1;
    wait_done7(done);
    check("stall_done", 32'(done), 32'h1);
    e = '{5'h11, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h12};
    check_codes("stall", q7[b7:$], e);

    // OUT_GO pulsed during SHIFT is ignored
    start7(1'b1, {28'h1000001, 1'b0});
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge CLOCK);
      if (t2_7) done = 1'b1;
    end
    check("retrig_type2_seen", 32'(done), 32'h1);
    @(posedge CLOCK); #1 go7 = 1'b1;
    @(posedge CLOCK); #1 go7 = 1'b0;
    wait_done7(done);
    check("retrig_done", 32'(done), 32'h1);
    e = '{5'h10, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h12};
    check_codes("retrig", q7[b7:$], e);
    check("retrig_t2_windows", 32'(t2_win.size() - bt2), 32'd6);

    // Reset in the middle of a TYPE2 window; the partly shifted word is then retyped
    start7(1'b1, {28'h1234567, 1'b0});
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge CLOCK);
      if (t2_7) done = 1'b1;
    end
    check("rstmid_type2_seen", 32'(done), 32'h1);
    repeat (20) @(posedge CLOCK);
    #1 rst = 1'b1;
    @(posedge CLOCK); #1 rst = 1'b0;
    @(negedge CLOCK);
    check("rstmid_type2", 32'(t2_7), 32'h0);
    check("rstmid_valid", 32'(valid7), 32'h0);
    check("rstmid_ready", 32'(rdy7), 32'h1);
    start7(1'b0, 29'h0);
    wait_done7(done);
    check("rstmid_done", 32'(done), 32'h1);
    e = '{5'h10, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h00, 5'h12};
    check_codes("rstmid", q7[b7:$], e);

    // Single-digit instance with a T0 injected at bit 10 before the capture word
    ld_val = 29'h10000000; ld_req++;
    @(posedge CLOCK); #1;
    b1 = q1.size(); bt2 = t2_win.size(); bt3 = t3_win.size();
    go1 = 1'b1;
    @(posedge CLOCK); #1 go1 = 1'b0;
    @(negedge CLOCK);
    check("d1_type1", 32'(t1_1), 32'h1);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge CLOCK);
      if (q1.size() > b1) done = 1'b1;
    end
    check("d1_sign_seen", 32'(done), 32'h1);
    inj_req++;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge CLOCK);
      if ((q1.size() - b1 >= 3) && rdy1) done = 1'b1;
    end
    check("d1_done", 32'(done), 32'h1);
    e = '{5'h10, 5'h08, 5'h12};
    check_codes("d1", q1[b1:$], e);
    check("d1_no_type2", 32'(t2_win.size() - bt2), 32'd0);
    check("d1_t3_windows", 32'(t3_win.size() - bt3), 32'd1);

    check("type2_type3_exclusive", 32'(both_hi), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/typ_out_seq.md
# typ_out_seq

Typewriter output sequencer for the G-15 line-19 output path. It reads the serial M19 recirculation stream and converts each word into a sign character, hex-digit characters and a carriage return. Characters go out to the typewriter driver over a valid/ack handshake. The block is the driving end of the TYPE1/TYPE2/TYPE3/READY interface consumed by `mem_top`: it requests the 4-bit line-19 shift between digits and the line clear at end of word.

## Interface
Parameters:
- `WORD_BITS`, 29: drum word length; bit 0 is the sign, bits are serial LSB first.
- `DIGITS`, 7: hex digits typed per word; legal range 1..7; digit nibble is bits 25..28, with bit 25 as LSB.

Ports:
- `CLOCK` in 1: single system clock. One clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `BIT_EN` in 1: one-`CLOCK` strobe per drum bit time; all drum-timed actions qualify on it.
- `T0` in 1: high during bit time 0 of every word.
- `M19` in 1: line-19 serial data, valid when `BIT_EN`=1.
- `OUT_GO` in 1: pulse that starts typing one word.
- `CHAR_ACK` in 1: typewriter driver accepts `CHAR_CODE`.
- `CHAR_CODE` out 5: 0x00–0x0F is a digit, 0x10 SPACE, 0x11 MINUS, 0x12 CR.
- `CHAR_VALID` out 1: `CHAR_CODE` is valid.
- `TYPE1` out 1: output cycle in progress.
- `TYPE2` out 1: shift line 19 left 4 bits; held for exactly one word time.
- `TYPE3` out 1: clear line 19; held for exactly one word time.
- `READY` out 1: idle, new `OUT_GO` accepted.

## Operation
- **Reset values.** `CHAR_CODE`=0, `CHAR_VALID`=0, `TYPE1`=0, `TYPE2`=0, `TYPE3`=0, `READY`=1. State is IDLE, bit counter is 0, digit counter is 0.
- **Bit counter.** On `BIT_EN`&`T0` the counter loads 0. On other `BIT_EN` strobes it increments, saturating at `WORD_BITS`-1. An early `T0` always resyncs the counter.
- **IDLE.** `READY`=1. `OUT_GO`=1 moves to SYNC. `OUT_GO` in any other state is ignored.
- **SYNC.** On `BIT_EN`&`T0`, sign ← `M19`. Load `CHAR_CODE` with MINUS if sign=1, otherwise SPACE. Go to SEND with kind=SIGN.
- **SEND.**
  - `CHAR_VALID`=1; `CHAR_CODE` is stable until it is accepted.
  - Acceptance happens on the first `CLOCK` edge with `CHAR_ACK`=1. `CHAR_VALID` drops on that edge.
  - `CHAR_ACK` is ignored when `CHAR_VALID`=0.
  - After acceptance:
    - SIGN goes to CAPD.
    - DIGIT with digit count < `DIGITS` goes to SHIFT.
    - DIGIT with digit count = `DIGITS` loads CR and returns to SEND with kind=CR.
    - CR goes to CLR.
- **CAPD.** Wait for the next `BIT_EN`&`T0`. Capture `M19` at bit counts 25, 26, 27, 28 into nibble bits 0..3. On the bit-28 strobe, load `CHAR_CODE`={0,nibble}, increment the digit count, and go to SEND with kind=DIGIT.
- **SHIFT.** `TYPE2` rises on the `CLOCK` edge of the next `BIT_EN`&`T0` and falls on the edge of the following `BIT_EN`&`T0`, giving exactly `WORD_BITS` bit times. On the falling edge, go to CAPD; that same `T0` starts the capture word.
- **CLR.** `TYPE3` uses the same one-word window as `TYPE2`. Then go to IDLE and clear the digit count.
- **TYPE1.** `TYPE1`=1 in every state except IDLE. `READY`=!`TYPE1`.
- **Reset mid-operation.** All outputs return to reset values on that edge, including dropping `TYPE2`/`TYPE3` mid-word. Line-19 integrity after a partial shift is not guaranteed by this block.

## Timing
- `OUT_GO` to SYNC: 1 `CLOCK`.
- Sign character: `CHAR_VALID` asserts on the edge of the first `T0` strobe after SYNC is entered.
- Digit character: `CHAR_VALID` asserts on the bit-28 strobe of the capture word.
- One word needs at least 2·`DIGITS` word times (each ≈ `WORD_BITS` bit times) plus handshake waits. For `DIGITS`=1 there is no SHIFT.
- A `CHAR_ACK` held high continuously is legal and accepts each character in 1 `CLOCK`.
- `TYPE2` and `TYPE3` are never high simultaneously.

## Configuration
- `TYP_ZERO_SUPPRESS_EN` defined: a digit nibble of 0 is sent as SPACE while no nonzero digit has yet been sent in this word. The last digit (count = `DIGITS`) is always sent as a numeral. The suppression flag clears in IDLE.
- `TYP_ZERO_SUPPRESS_EN` undefined: every digit is sent as its numeral code.

## Structure
- Package `typ_out_pkg`:
  - character code constants CH_SPACE, CH_MINUS, CH_CR;
  - state enum typedef (IDLE, SYNC, SEND, CAPD, SHIFT, CLR);
  - character-kind enum (SIGN, DIGIT, CR);
  - `WORD_BITS` default.
- Sub-module `typ_bit_timer`: bit counter from `BIT_EN`/`T0`, with a `word_start` strobe output and a bit-count output.

## Test plan
Bench model: line-19 is a 29-bit word. `TYPE2` shifts it left 4 bits within each word time; `TYPE3` zeroes it.

- **Basic word.** Word sign=1, digits 0x0012345, `DIGITS`=7, `CHAR_ACK` tied 1, macro off → codes 0x11, 0x00, 0x00, 0x01, 0x02, 0x03, 0x04, 0x05, 0x12. Six `TYPE2` windows of 29 bit times each, then one `TYPE3` window, then `READY`=1.
- **Zero suppress.** Same word with `TYP_ZERO_SUPPRESS_EN` defined → 0x11, 0x10, 0x10, 0x01, 0x02, 0x03, 0x04, 0x05, 0x12. Word 0, sign 0 → 0x10 ×7, then 0x00, then 0x12.
- **Handshake stall.** Hold `CHAR_ACK` low for 50 `CLOCK`s on the sign character → `CHAR_CODE` is stable and `CHAR_VALID`=1 throughout. No `TYPE2` occurs until after the ack.
- **Busy retrigger.** `OUT_GO` pulsed during SHIFT → no restart; the character sequence is unchanged.
- **Reset mid-operation.** `rst` during a `TYPE2` window → next edge shows `TYPE2`=0, `CHAR_VALID`=0, `READY`=1. A following `OUT_GO` types the (shifted) word from its sign.
- **Resync and single digit.** `T0` injected at bit count 10 → counter restarts at 0 and capture uses the realigned bits 25..28. With `DIGITS`=1, word 0x8 in bits 25..28 → 0x10, 0x08, 0x12 with no `TYPE2`.
